// File: rtl/cve2_obi_wb_bridge_if.sv
// Bus bundles for the CVE2 OBI-to-Wishbone bridge: the core-side OBI request/response
// channel and the classic Wishbone B4 channel.

interface cve2_obi_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req;
   logic                  gnt;
   logic                  we;
   logic [DATA_W/8-1:0]   be;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;
   logic                  err;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

interface cve2_wb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [DATA_W/8-1:0]   sel;
   logic [ADDR_W-1:0]     adr;
   logic [DATA_W-1:0]     wdat;
   logic [DATA_W-1:0]     rdat;
   logic                  ack;
   logic                  err;

   modport master (output cyc, stb, we, sel, adr, wdat, input rdat, ack, err);
   modport slave  (input cyc, stb, we, sel, adr, wdat, output rdat, ack, err);
endinterface

// File: rtl/cve2_obi_wb_bridge.sv
// Converts one OBI req/gnt/rvalid transaction from the CVE2 core into a single classic
// Wishbone B4 cycle; one outstanding transaction, bus error and timeout reported via err.

module cve2_obi_wb_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   cve2_obi_if.slave  obi,
   cve2_wb_if.master  wb
);

   localparam int BE_W  = DATA_W / 8;
   // Keep the counter at least one bit wide when the timeout is disabled.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state;
   logic [CNT_W-1:0]    cnt;
   logic                cyc_q;
   logic                stb_q;
   logic                we_q;
   logic [BE_W-1:0]     sel_q;
   logic [ADDR_W-1:0]   adr_q;
   logic [DATA_W-1:0]   dat_q;
   logic                rvalid_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                timed_out;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign obi.gnt   = obi.req && (state == IDLE);
   assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         cnt      <= '0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (obi.gnt) begin
                  we_q  <= obi.we;
                  sel_q <= obi.be;
                  adr_q <= obi.addr;
                  dat_q <= obi.wdata;
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  cnt   <= '0;
                  state <= BUS;
               end
            end
            BUS: begin
               // err takes priority over a simultaneous ack; read data only on a clean read ack.
               if (wb.ack || wb.err) begin
                  cyc_q    <= 1'b0;
                  stb_q    <= 1'b0;
                  err_q    <= wb.err;
                  rdata_q  <= (!we_q && wb.ack && !wb.err) ? wb.rdat : '0;
                  rvalid_q <= 1'b1;
                  state    <= RESP;
               end else if (timed_out) begin
                  cyc_q    <= 1'b0;
                  stb_q    <= 1'b0;
                  err_q    <= 1'b1;
                  rdata_q  <= '0;
                  rvalid_q <= 1'b1;
                  state    <= RESP;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            RESP: begin
               rvalid_q <= 1'b0;
               err_q    <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign wb.cyc     = cyc_q;
   assign wb.stb     = stb_q;
   assign wb.we      = we_q;
   assign wb.sel     = sel_q;
   assign wb.adr     = adr_q;
   assign wb.wdat    = dat_q;
   assign obi.rvalid = rvalid_q;
   assign obi.rdata  = rdata_q;
   assign obi.err    = err_q;

endmodule
